// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: data-memory handshake, pipeline stall, load formatting.
// Define MEM_TIMEOUT_EN to abort a BUSY access after TIMEOUT_CYCLES.

module mem_stage_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        validM,
    input  logic        RegWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic        MemWriteM,
    input  logic        MemReadM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        RegWriteMo,
    output logic [1:0]  ResultSrcMo,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        misalignM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [2:0]  fmtF3;
    logic [1:0]  fmtOff;
    logic        fault;

    logic        isByte;
    logic        isHalf;
    logic        isWord;
    logic        acc;
    logic        mis;
    logic [3:0]  laneStrb;
    logic [31:0] laneData;

    logic        fmtByte;
    logic        fmtHalf;
    logic [7:0]  rdByte;
    logic [15:0] rdHalf;
    logic [31:0] loadFmt;

    // Elaborates only for a counter too narrow to hold TIMEOUT_CYCLES.
    if (TO_W < 1 || TIMEOUT_CYCLES >= (1 << TO_W)) begin : gBadTimeoutCfg
    end

    assign isByte = (funct3M[1:0] == 2'b00);
    assign isHalf = (funct3M[1:0] == 2'b01);
    assign isWord = funct3M[1];

    assign acc = validM & (MemReadM | MemWriteM);
    assign mis = acc & ((isHalf & ALUResultM[0])
                      | (isWord & (|ALUResultM[1:0])));

    assign ResultSrcMo = ResultSrcM;

    always_comb begin
        laneStrb = 4'b1111;
        laneData = WriteDataM;
        unique case (1'b1)
            isByte: begin
                laneStrb = 4'b0001 << ALUResultM[1:0];
                laneData = {4{WriteDataM[7:0]}};
            end
            isHalf: begin
                laneStrb = 4'b0011 << ALUResultM[1:0];
                laneData = {2{WriteDataM[15:0]}};
            end
            default: ;
        endcase
    end

    assign fmtByte = (fmtF3[1:0] == 2'b00);
    assign fmtHalf = (fmtF3[1:0] == 2'b01);

    always_comb begin
        unique case (fmtOff)
            2'd0:    rdByte = dmem_rdata[7:0];
            2'd1:    rdByte = dmem_rdata[15:8];
            2'd2:    rdByte = dmem_rdata[23:16];
            default: rdByte = dmem_rdata[31:24];
        endcase
        rdHalf  = fmtOff[1] ? dmem_rdata[31:16]
                            : dmem_rdata[15:0];
        loadFmt = dmem_rdata;
        unique case (1'b1)
            fmtByte: loadFmt = {{24{rdByte[7] & ~fmtF3[2]}},
                                rdByte};
            fmtHalf: loadFmt = {{16{rdHalf[15] & ~fmtF3[2]}},
                                rdHalf};
            default: ;
        endcase
    end

    // Stall and write-enable must act in the same cycle the op sits in M.
    always_comb begin
        StallM     = 1'b0;
        RegWriteMo = 1'b0;
        misalignM  = 1'b0;
        if (!reset) begin
            unique case (state)
                IDLE: begin
                    StallM     = acc & ~mis;
                    misalignM  = mis;
                    RegWriteMo = RegWriteM & validM & ~acc;
                end
                BUSY: StallM = 1'b1;
                DONE: begin
                    RegWriteMo = RegWriteM & ~fault;
                    misalignM  = fault;
                end
                default: ;
            endcase
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LAST =
        TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] toCnt;
    logic            toHit;

    assign toHit = (toCnt == TO_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            toCnt <= '0;
        end else if (state == IDLE) begin
            toCnt <= '0;
        end else if (state == BUSY) begin
            toCnt <= toCnt + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_wstrb <= '0;
            fmtF3      <= '0;
            fmtOff     <= '0;
            ReadDataM  <= '0;
            fault      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    fault <= 1'b0;
                    if (acc & ~mis) begin
                        state      <= BUSY;
                        dmem_req   <= 1'b1;
                        dmem_we    <= MemWriteM;
                        dmem_addr  <= {ALUResultM[31:2], 2'b00};
                        dmem_wdata <= laneData;
                        dmem_wstrb <= MemWriteM ? laneStrb : 4'b0000;
                        fmtF3      <= funct3M;
                        fmtOff     <= ALUResultM[1:0];
                    end
                end
                BUSY: begin
                    if (dmem_ready) begin
                        dmem_req <= 1'b0;
                        state    <= DONE;
                        if (!dmem_we) begin
                            ReadDataM <= loadFmt;
                        end
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (toHit) begin
                        dmem_req <= 1'b0;
                        fault    <= 1'b1;
                        state    <= DONE;
                    end
`endif
                end
                DONE: begin
                    fault <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed plan steps plus
// randomized loads/stores/ALU ops against a transaction-level model.

module tb_mem_stage_ctrl;

    localparam int TO_CYC = 4;
`ifdef MEM_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        validM = 1'b0;
    logic        RegWriteM = 1'b0;
    logic [1:0]  ResultSrcM = 2'b00;
    logic        MemWriteM = 1'b0;
    logic        MemReadM = 1'b0;
    logic [2:0]  funct3M = 3'd0;
    logic [31:0] ALUResultM = '0;
    logic [31:0] WriteDataM = '0;
    logic        RegWriteMo;
    logic [1:0]  ResultSrcMo;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        misalignM;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ready = 1'b0;
    logic [31:0] dmem_rdata = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage_ctrl #(
        .TIMEOUT_CYCLES(TO_CYC),
        .TO_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .validM(validM),
        .RegWriteM(RegWriteM),
        .ResultSrcM(ResultSrcM),
        .MemWriteM(MemWriteM),
        .MemReadM(MemReadM),
        .funct3M(funct3M),
        .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM),
        .RegWriteMo(RegWriteMo),
        .ResultSrcMo(ResultSrcMo),
        .ReadDataM(ReadDataM),
        .StallM(StallM),
        .misalignM(misalignM),
        .dmem_req(dmem_req),
        .dmem_we(dmem_we),
        .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata),
        .dmem_wstrb(dmem_wstrb),
        .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] refLoad(input logic [2:0] f3,
                                            input int unsigned off,
                                            input logic [31:0] rd);
        int unsigned b;
        int unsigned h;
        b = 32'(rd >> (8 * off)) % 256;
        h = 32'(rd >> (16 * (off / 2))) % 65536;
        case (f3)
            3'd0:    return (b < 128) ? b : b + 32'hFFFF_FF00;
            3'd4:    return b;
            3'd1:    return (h < 32768) ? h : h + 32'hFFFF_0000;
            3'd5:    return h;
            default: return rd;
        endcase
    endfunction

    function automatic logic [3:0] refStrb(input logic [2:0] f3,
                                           input int unsigned off);
        case (f3)
            3'd0:    return 4'(1 << off);
            3'd1:    return 4'(3 << off);
            default: return 4'd15;
        endcase
    endfunction

    function automatic logic [31:0] refWdata(input logic [2:0] f3,
                                             input logic [31:0] wd);
        case (f3)
            3'd0:    return (wd % 256) * 32'h0101_0101;
            3'd1:    return (wd % 65536) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    // waitC = number of unanswered request cycles; negative = never.
    task automatic runOp(input logic v, input logic rd, input logic wr,
                         input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rdat,
                         input logic rw, input int waitC,
                         input string tag);
        int unsigned off;
        bit acc, mis, fault, done;
        int stalls, reqs, expBusy, sz;
        off = addr % 4;
        sz = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
        acc = v && (rd || wr);
        mis = acc && (off % sz != 0);
        fault = acc && !mis && TO_EN && (waitC < 0 || waitC >= TO_CYC);
        expBusy = (!acc || mis) ? 0 : fault ? TO_CYC : waitC + 1;
        @(negedge clk);
        validM     = v;
        MemReadM   = rd;
        MemWriteM  = wr;
        funct3M    = f3;
        ALUResultM = addr;
        WriteDataM = wd;
        RegWriteM  = rw;
        ResultSrcM = rd ? 2'b01 : 2'($urandom_range(0, 2));
        dmem_ready = 1'($urandom);
        dmem_rdata = $urandom;
        stalls = 0;
        reqs = 0;
        done = 0;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            if (cyc > 0) @(negedge clk);
            #2;
            if (cyc == 0)
                chk({tag, ".src"}, 32'(ResultSrcMo), 32'(ResultSrcM));
            dmem_ready = 1'b0;
            if (dmem_req) begin
                reqs++;
                chk({tag, ".addr"}, dmem_addr, addr - off);
                chk({tag, ".we"}, 32'(dmem_we), 32'(wr));
                if (wr) begin
                    chk({tag, ".strb"}, 32'(dmem_wstrb),
                        32'(refStrb(f3, off)));
                    chk({tag, ".wdata"}, dmem_wdata, refWdata(f3, wd));
                end
                dmem_ready = (waitC >= 0 && reqs == waitC + 1);
                dmem_rdata = dmem_ready ? rdat : $urandom;
            end
            if (StallM) begin
                stalls++;
            end else begin
                done = 1;
                chk({tag, ".rw"}, 32'(RegWriteMo),
                    32'(!acc ? (rw && v) : (mis || fault) ? 1'b0 : rw));
                chk({tag, ".mis"}, 32'(misalignM), 32'(mis || fault));
                if (acc && !mis && !fault && rd && !wr)
                    chk({tag, ".rdata"}, ReadDataM,
                        refLoad(f3, off, rdat));
            end
        end
        chk({tag, ".bound"}, 32'(done), 32'd1);
        chk({tag, ".stalls"}, stalls,
            (acc && !mis) ? expBusy + 1 : 0);
        chk({tag, ".reqs"}, reqs, expBusy);
    endtask

    logic [2:0] ldF3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    initial begin
        #2;
        chk("rst.req", 32'(dmem_req), 32'd0);
        chk("rst.stall", 32'(StallM), 32'd0);
        chk("rst.rw", 32'(RegWriteMo), 32'd0);
        chk("rst.mis", 32'(misalignM), 32'd0);
        chk("rst.strb", 32'(dmem_wstrb), 32'd0);
        chk("rst.rdata", ReadDataM, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        runOp(1, 1, 0, 3'd2, 32'h100, 0, 32'hDEADBEEF, 1, 0, "lw");
        runOp(1, 1, 0, 3'd0, 32'h103, 0, 32'h80FFFFFF, 1, 1, "lb");
        chk("lb.exact", ReadDataM, 32'hFFFFFF80);
        runOp(1, 1, 0, 3'd4, 32'h103, 0, 32'h80FFFFFF, 1, 0, "lbu");
        chk("lbu.exact", ReadDataM, 32'h00000080);
        runOp(1, 0, 1, 3'd1, 32'h102, 32'h0000ABCD, 0, 0, 2, "sh");
        runOp(1, 1, 0, 3'd2, 32'h101, 0, 0, 1, 0, "lwmis");
        runOp(1, 0, 0, 3'd0, 32'h55, 0, 0, 1, 0, "alu");
        runOp(0, 0, 0, 3'd0, 32'h55, 0, 0, 1, 0, "bubble");
        runOp(0, 1, 0, 3'd2, 32'h40, 0, 0, 1, 0, "ldbubble");

        @(negedge clk);
        validM = 1; MemReadM = 1; MemWriteM = 0;
        funct3M = 3'd2; ALUResultM = 32'h200;
        RegWriteM = 1; dmem_ready = 0;
        @(negedge clk);
        #2;
        chk("rb.req", 32'(dmem_req), 32'd1);
        reset = 1'b1;
        #1;
        chk("rb.reqdrop", 32'(dmem_req), 32'd0);
        chk("rb.stall", 32'(StallM), 32'd0);
        @(negedge clk);
        validM = 0; MemReadM = 0;
        reset = 1'b0;
        #2;
        chk("rb.idle", 32'(StallM), 32'd0);
        @(negedge clk);
        #2;
        chk("rb.noreq", 32'(dmem_req), 32'd0);
        chk("rb.nomis", 32'(misalignM), 32'd0);

`ifdef MEM_TIMEOUT_EN
        runOp(1, 1, 0, 3'd2, 32'h300, 0, 0, 1, -1, "tmo");
`endif

        for (int i = 0; i < 60; i++) begin
            int kind;
            logic [2:0] f3;
            logic [31:0] a;
            kind = $urandom_range(0, 3);
            f3 = (kind == 1) ? ldF3[$urandom_range(0, 4)]
                             : 3'($urandom_range(0, 2));
            a = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1]) a = a & 32'hFFFF_FFFC;
                else if (f3[0]) a = a & 32'hFFFF_FFFE;
            end
            case (kind)
                0: runOp(1'($urandom_range(0, 3) != 0), 0, 0, f3, a,
                         $urandom, 0, 1'($urandom), 0, "rALU");
                1: runOp(1, 1, 0, f3, a, $urandom, $urandom,
                         1'($urandom), $urandom_range(0, 3), "rLD");
                2: runOp(1, 0, 1, f3, a, $urandom, $urandom,
                         1'($urandom), $urandom_range(0, 3), "rST");
                default: runOp(0, 1'($urandom), 1'($urandom), f3, a,
                               $urandom, 0, 1'($urandom), 0, "rBUB");
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
